id_stage_pipe: RTL and testbench

Parametrised decode stage for the in-order pipeline, placed between the fetch stage and EX. It splits the instruction and reads the internal multi-ported register file with EX/MEM/WB forwarding. It detects load-use hazards and resolves branches and jumps in ID. Results go to EX through a registered valid/ready ID/EX slot, with flush support and a saturating stall counter.

---
 rtl/id_pkg.sv | 46 ++++
 rtl/id_ctrl.sv | 94 +++++++++
 rtl/id_stage_pipe.sv | 145 ++++++++++++++
 tb/tb_id_stage_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcode/funct encodings,
// control-field selector values, branch kinds and the control word.
package id_pkg;

  localparam logic [5:0]
    OP_SPECIAL = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE     = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
    OP_SLTIU   = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E,
    OP_LUI     = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B;

  localparam logic [5:0]
    FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08,
    FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
    FN_AND = 6'h24, FN_OR   = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
    FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [3:0]
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,  ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6,  ALU_SLTU = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;

  localparam logic       A1_RS = 1'b0, A1_SA = 1'b1;
  localparam logic       A2_RT = 1'b0, A2_IMM = 1'b1;
  localparam logic [1:0] ML_NONE = 2'd0, ML_WORD = 2'd2;
  localparam logic [1:0] WA_RD = 2'd0, WA_RT = 2'd1, WA_RA = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_LINK = 2'd2;

  typedef enum logic [2:0] {
    BR_NONE, BR_BEQ, BR_BNE, BR_J, BR_JAL, BR_JR
  } br_kind_e;

  typedef struct packed {
    logic [3:0] alusel;
    logic       aluin1;
    logic       aluin2;
    logic [1:0] memlen;
    logic       memwe;
    logic       regwe;
    logic [1:0] regwa_sel;
    logic [1:0] regwd_sel;
    logic       use_rs;
    logic       use_rt;
    br_kind_e   br_kind;
  } ctrl_t;

endpackage

// File: rtl/id_ctrl.sv
// Combinational instruction decoder: opcode/funct/rt to control word.
module id_ctrl
  import id_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (op)
      OP_SPECIAL: begin
        ctrl.regwe  = 1'b1;
        ctrl.use_rs = 1'b1;
        ctrl.use_rt = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctrl.alusel = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alusel = ALU_SUB;
          FN_AND:          ctrl.alusel = ALU_AND;
          FN_OR:           ctrl.alusel = ALU_OR;
          FN_XOR:          ctrl.alusel = ALU_XOR;
          FN_NOR:          ctrl.alusel = ALU_NOR;
          FN_SLT:          ctrl.alusel = ALU_SLT;
          FN_SLTU:         ctrl.alusel = ALU_SLTU;
          FN_SLL, FN_SRL, FN_SRA: begin
            ctrl.aluin1 = A1_SA;
            ctrl.use_rs = 1'b0;
            ctrl.alusel = (funct == FN_SLL) ? ALU_SLL :
                          (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
          end
          FN_JR: begin
            ctrl.regwe   = 1'b0;
            ctrl.use_rt  = 1'b0;
            ctrl.br_kind = BR_JR;
          end
          default: begin
            ctrl.regwe  = 1'b0;
            ctrl.use_rs = 1'b0;
            ctrl.use_rt = 1'b0;
          end
        endcase
      end
      OP_J:   ctrl.br_kind = BR_J;
      OP_JAL: begin
        ctrl.br_kind   = BR_JAL;
        ctrl.regwe     = 1'b1;
        ctrl.regwa_sel = WA_RA;
        ctrl.regwd_sel = WD_LINK;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.use_rs  = 1'b1;
        ctrl.use_rt  = 1'b1;
        ctrl.alusel  = ALU_SUB;
        ctrl.br_kind = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
      end
      OP_LW: begin
        ctrl.use_rs    = 1'b1;
        ctrl.aluin2    = A2_IMM;
        ctrl.memlen    = ML_WORD;
        ctrl.regwe     = 1'b1;
        ctrl.regwa_sel = WA_RT;
        ctrl.regwd_sel = WD_MEM;
      end
      OP_SW: begin
        ctrl.use_rs = 1'b1;
        ctrl.use_rt = 1'b1;
        ctrl.aluin2 = A2_IMM;
        ctrl.memlen = ML_WORD;
        ctrl.memwe  = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.use_rs    = (op != OP_LUI);
        ctrl.aluin2    = A2_IMM;
        ctrl.regwe     = 1'b1;
        ctrl.regwa_sel = WA_RT;
        case (op)
          OP_SLTI:  ctrl.alusel = ALU_SLT;
          OP_SLTIU: ctrl.alusel = ALU_SLTU;
          OP_ANDI:  ctrl.alusel = ALU_AND;
          OP_ORI:   ctrl.alusel = ALU_OR;
          OP_XORI:  ctrl.alusel = ALU_XOR;
          OP_LUI:   ctrl.alusel = ALU_LUI;
          default:  ctrl.alusel = ALU_ADD;
        endcase
      end
      default: ctrl = '0;
    endcase
    // r0 never needs forwarding or a hazard stall
    if (rt == '0) ctrl.use_rt = 1'b0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: register file with EX/MEM/WB forwarding, load-use hazard
// detection, branch resolution and a registered valid/ready ID/EX slot.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREG  = 32,
  parameter  int CNT_W = 16,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  pc,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_wa,
  input  logic [XLEN-1:0]  wb_wd,
  input  logic             ex_we,
  input  logic [AW-1:0]    ex_wa,
  input  logic [XLEN-1:0]  ex_wd,
  input  logic             ex_is_load,
  input  logic             me_we,
  input  logic [AW-1:0]    me_wa,
  input  logic [XLEN-1:0]  me_wd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output ctrl_t            out_ctrl,
  output logic [XLEN-1:0]  out_rs1,
  output logic [XLEN-1:0]  out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_sa,
  output logic [AW-1:0]    out_rt,
  output logic [AW-1:0]    out_rd,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [XLEN-1:0] rf [NREG];
  logic [AW-1:0]   rs_a, rt_a, rd_a;
  logic [AW-1:0]   src_a [2];
  logic [XLEN-1:0] src_v [2];
  logic [XLEN-1:0] imm_sext, pc4, target;
  logic            hazard, accept, taken;
  ctrl_t           ctrl;

  assign rs_a     = inst[21 +: AW];
  assign rt_a     = inst[16 +: AW];
  assign rd_a     = inst[11 +: AW];
  assign src_a[0] = rs_a;
  assign src_a[1] = rt_a;
  assign imm_sext = {{(XLEN-16){inst[15]}}, inst[15:0]};
  assign pc4      = pc + XLEN'(4);

  id_ctrl u_ctrl (
    .op    (inst[31:26]),
    .funct (inst[5:0]),
    .rt    (inst[20:16]),
    .ctrl  (ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && wb_wa != '0) begin
      rf[wb_wa] <= wb_wd;
    end
  end

  // EX results from a load are not ready yet; those cases stall instead
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      src_v[i] = rf[src_a[i]];
      if (src_a[i] == '0)                                src_v[i] = '0;
      else if (ex_we && ex_wa == src_a[i] && !ex_is_load) src_v[i] = ex_wd;
      else if (me_we && me_wa == src_a[i])               src_v[i] = me_wd;
      else if (wb_we && wb_wa == src_a[i])               src_v[i] = wb_wd;
    end
  end

  assign hazard   = ex_is_load && ex_we && ex_wa != '0 &&
                    ((ctrl.use_rs && ex_wa == rs_a) || (ctrl.use_rt && ex_wa == rt_a));
  assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    taken  = 1'b0;
    target = pc4 + {imm_sext[XLEN-3:0], 2'b00};
    case (ctrl.br_kind)
      BR_BEQ: taken = (src_v[0] == src_v[1]);
      BR_BNE: taken = (src_v[0] != src_v[1]);
      BR_J, BR_JAL: begin
        taken  = 1'b1;
        target = {pc4[XLEN-1:28], inst[25:0], 2'b00};
      end
      BR_JR: begin
        taken  = 1'b1;
        target = src_v[0];
      end
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_ctrl       <= '0;
      out_rs1        <= '0;
      out_rs2        <= '0;
      out_imm        <= '0;
      out_sa         <= '0;
      out_rt         <= '0;
      out_rd         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall_cnt      <= '0;
    end else begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid      <= 1'b1;
        out_ctrl       <= ctrl;
        out_rs1        <= src_v[0];
        out_rs2        <= src_v[1];
        // link instructions carry the return address in the immediate lane
        out_imm        <= (ctrl.regwd_sel == WD_LINK) ? pc + XLEN'(8) : imm_sext;
        out_sa         <= {{(XLEN-5){1'b0}}, inst[10:6]};
        out_rt         <= rt_a;
        out_rd         <= rd_a;
        redirect_valid <= taken;
        redirect_pc    <= taken ? target : '0;
      end else if (!out_valid || out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && hazard && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe with hand-computed expectations.
module tb_id_stage_pipe;
  import id_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int CNT_W = 2;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, wb_we, ex_we, ex_is_load, me_we, flush;
  logic             out_valid, out_ready, redirect_valid;
  logic [31:0]      inst;
  logic [XLEN-1:0]  pc, wb_wd, ex_wd, me_wd;
  logic [AW-1:0]    wb_wa, ex_wa, me_wa, out_rt, out_rd;
  logic [XLEN-1:0]  out_rs1, out_rs2, out_imm, out_sa, redirect_pc;
  logic [CNT_W-1:0] stall_cnt;
  ctrl_t            out_ctrl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .ex_we(ex_we), .ex_wa(ex_wa), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
    .me_we(me_we), .me_wa(me_wa), .me_wd(me_wd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_sa(out_sa), .out_rt(out_rt), .out_rd(out_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst = '0; pc = '0; flush = 1'b0; out_ready = 1'b1;
    wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
    ex_we = 1'b0; ex_wa = '0; ex_wd = '0; ex_is_load = 1'b0;
    me_we = 1'b0; me_wa = '0; me_wd = '0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_out_rs1", out_rs1, 0);
    rst = 1'b0;

    // forwarding chain on r5
    wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h11;
    tick();
    wb_we = 1'b0;
    inst = rtype(5'd5, 5'd5, 5'd6, 5'd0, FN_ADD); in_valid = 1'b1;
    #1 check("add_in_ready", in_ready, 1);
    tick();
    check("array_valid", out_valid, 1);
    check("array_rs1", out_rs1, 32'h11);
    check("array_rs2", out_rs2, 32'h11);
    check("array_rd", out_rd, 6);
    check("array_rt", out_rt, 5);
    check("array_regwe", out_ctrl.regwe, 1);
    me_we = 1'b1; me_wa = 5'd5; me_wd = 32'h22;
    tick();
    check("mem_fwd_rs1", out_rs1, 32'h22);
    ex_we = 1'b1; ex_wa = 5'd5; ex_wd = 32'h33;
    tick();
    check("ex_fwd_rs1", out_rs1, 32'h33);
    check("ex_fwd_rs2", out_rs2, 32'h33);

    // WB write-through on r7 plus shamt extraction
    ex_we = 1'b0; me_we = 1'b0;
    wb_we = 1'b1; wb_wa = 5'd7; wb_wd = 32'h77;
    inst = rtype(5'd7, 5'd5, 5'd9, 5'd9, FN_SLL);
    tick();
    wb_we = 1'b0;
    check("wb_thru_rs1", out_rs1, 32'h77);
    check("sll_rs2", out_rs2, 32'h11);
    check("sll_sa", out_sa, 9);
    check("sll_aluin1", out_ctrl.aluin1, A1_SA);

    // r0 source is always zero, even with an EX write or load aimed at r0
    ex_we = 1'b1; ex_wa = 5'd0; ex_wd = 32'h55; ex_is_load = 1'b0;
    inst = rtype(5'd0, 5'd0, 5'd10, 5'd0, FN_ADD);
    tick();
    check("r0_ex_rs1", out_rs1, 0);
    ex_is_load = 1'b1;
    #1 check("r0_load_in_ready", in_ready, 1);
    tick();
    check("r0_load_rs1", out_rs1, 0);
    check("r0_load_valid", out_valid, 1);

    // load-use stall on r8
    ex_wa = 5'd8; ex_wd = 32'hDEAD;
    inst = rtype(5'd8, 5'd0, 5'd11, 5'd0, FN_ADD);
    #1 check("lu_in_ready", in_ready, 0);
    tick();
    check("lu_bubble", out_valid, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    ex_we = 1'b0; ex_is_load = 1'b0;
    me_we = 1'b1; me_wa = 5'd8; me_wd = 32'hABCD;
    #1 check("lu_resume_ready", in_ready, 1);
    tick();
    check("lu_resume_valid", out_valid, 1);
    check("lu_resume_rs1", out_rs1, 32'hABCD);
    check("lu_stall_hold", stall_cnt, 1);

    // branches with forwarded operands r1 (MEM) and r2 (EX)
    me_wa = 5'd1; me_wd = 32'd7;
    ex_we = 1'b1; ex_wa = 5'd2; ex_wd = 32'd7;
    pc = 32'h100; inst = itype(OP_BEQ, 5'd1, 5'd2, 16'd4);
    tick();
    check("beq_redirect", redirect_valid, 1);
    check("beq_target", redirect_pc, 32'h114);
    check("beq_kind", out_ctrl.br_kind, BR_BEQ);
    in_valid = 1'b0;
    tick();
    check("beq_pulse_end", redirect_valid, 0);
    check("idle_bubble", out_valid, 0);
    inst = itype(OP_BNE, 5'd1, 5'd2, 16'd4); in_valid = 1'b1;
    tick();
    check("bne_eq_redirect", redirect_valid, 0);
    check("bne_eq_valid", out_valid, 1);
    ex_wd = 32'd8;
    tick();
    check("bne_ne_redirect", redirect_valid, 1);
    check("bne_ne_target", redirect_pc, 32'h114);
    ex_we = 1'b0; me_wa = 5'd3; me_wd = 32'h1234;
    inst = rtype(5'd3, 5'd0, 5'd0, 5'd0, FN_JR);
    tick();
    check("jr_redirect", redirect_valid, 1);
    check("jr_target", redirect_pc, 32'h1234);
    me_we = 1'b0;
    pc = 32'h0040_0000; inst = {OP_JAL, 26'h10};
    tick();
    check("jal_redirect", redirect_valid, 1);
    check("jal_target", redirect_pc, 32'h40);
    check("jal_link_sel", out_ctrl.regwd_sel, WD_LINK);
    check("jal_link_val", out_imm, 32'h0040_0008);
    check("jal_ra_sel", out_ctrl.regwa_sel, WA_RA);

    // backpressure holds payload bit-stable
    inst = rtype(5'd5, 5'd5, 5'd12, 5'd0, FN_ADD);
    tick();
    check("bp_load_rd", out_rd, 12);
    out_ready = 1'b0;
    inst = rtype(5'd7, 5'd7, 5'd13, 5'd0, FN_ADD);
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_rd", out_rd, 12);
      check("bp_rs1", out_rs1, 32'h11);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_release_rd", out_rd, 13);
    check("bp_release_rs1", out_rs1, 32'h77);

    // flush kills slot and refuses the offered input
    flush = 1'b1;
    inst = rtype(5'd5, 5'd0, 5'd14, 5'd0, FN_ADD);
    #1 check("flush_in_ready", in_ready, 0);
    tick();
    check("flush_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("flush_not_consumed", out_valid, 0);

    // saturating stall counter; flush cycles do not count
    in_valid = 1'b1; flush = 1'b1;
    ex_we = 1'b1; ex_wa = 5'd8; ex_is_load = 1'b1;
    inst = rtype(5'd8, 5'd0, 5'd16, 5'd0, FN_ADD);
    tick();
    check("flush_no_count", stall_cnt, 1);
    flush = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("sat_cnt", stall_cnt, (1 + k > 3) ? 3 : 1 + k);
    end

    // reset mid-transfer
    ex_we = 1'b0; ex_is_load = 1'b0;
    pc = 32'h0040_0000; inst = {OP_JAL, 26'h10};
    tick();
    check("pre_rst_redirect", redirect_valid, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_redirect", redirect_valid, 0);
    check("mid_rst_redirect_pc", redirect_pc, 0);
    check("mid_rst_imm", out_imm, 0);
    check("mid_rst_ctrl", out_ctrl, 0);
    check("mid_rst_cnt", stall_cnt, 0);
    rst = 1'b0;
    inst = rtype(5'd5, 5'd5, 5'd6, 5'd0, FN_ADD);
    tick();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_rf_clear", out_rs1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
